// File: rtl/icache_axi_responder_pkg.sv
// Shared constants, state encoding and small helpers for the instruction-cache
// line responder.
package icache_axi_responder_pkg;

  localparam int DATA_W        = 32;
  localparam int ADDR_W        = 32;
  localparam int BEATS         = 4;
  localparam int BEAT_W        = 2;
  localparam int LINE_OFFSET_W = 4;
  localparam int FCNT_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
    return beat == BEAT_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/icache_axi_responder_ram.sv
// Backing instruction store: one synchronous read port (1-cycle latency) and one
// preload write port. A same-cycle read and write of one word returns the old data.
import icache_axi_responder_pkg::*;

module icache_axi_responder_ram #(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_r [0:(1 << RAM_AW)-1];
  logic [DATA_W-1:0] rdata_r;

  // Preload write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; non-blocking update of the array makes this read-first.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/icache_axi_responder.sv
// Serves 16-byte instruction-cache line fills: fetches four words into a line
// buffer, then returns them as an in-order four-beat read burst.
import icache_axi_responder_pkg::*;

module icache_axi_responder #(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  output logic              i_arready,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  input  logic              ld_we,
  input  logic [RAM_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata
);

  localparam int LINE_W = RAM_AW + 2 - LINE_OFFSET_W;

  state_t              state_r;
  state_t              state_s;
  logic [FCNT_W-1:0]   fcnt_r;
  logic [FCNT_W-1:0]   fcnt_s;
  logic [BEAT_W-1:0]   beat_r;
  logic [BEAT_W-1:0]   beat_s;
  logic [LINE_W-1:0]   line_r;
  logic [LINE_W-1:0]   line_s;
  logic [DATA_W-1:0]   buf_r [BEATS];
  logic                ram_re_s;
  logic [RAM_AW-1:0]   ram_raddr_s;
  logic [DATA_W-1:0]   ram_rdata_s;
  logic                buf_we_s;
  logic [BEAT_W-1:0]   buf_idx_s;
  logic                unused_addr_s;

  // Upper bits alias modulo RAM size; the byte offset within the line is irrelevant.
  assign unused_addr_s = ^{i_araddr[ADDR_W-1:RAM_AW+2], i_araddr[LINE_OFFSET_W-1:0]};

  icache_axi_responder_ram #(
    .RAM_AW (RAM_AW)
  ) inst_ram (
    .clk   (clk),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s),
    .we    (ld_we),
    .waddr (ld_addr),
    .wdata (ld_wdata)
  );

  // Next-state logic: read issue runs one cycle ahead of buffer capture.
  always_comb begin
    state_s     = state_r;
    fcnt_s      = fcnt_r;
    beat_s      = beat_r;
    line_s      = line_r;
    ram_re_s    = 1'b0;
    ram_raddr_s = {line_r, fcnt_r[BEAT_W-1:0]};
    buf_we_s    = 1'b0;
    buf_idx_s   = fcnt_r[BEAT_W-1:0] - BEAT_W'(1);
    case (state_r)
      ST_IDLE: begin
        if (i_arvalid && i_arready) begin
          line_s  = i_araddr[RAM_AW+1:LINE_OFFSET_W];
          fcnt_s  = {FCNT_W{1'b0}};
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ram_re_s = (fcnt_r < FCNT_W'(BEATS));
        buf_we_s = (fcnt_r != {FCNT_W{1'b0}});
        if (fcnt_r == FCNT_W'(BEATS)) begin
          fcnt_s  = {FCNT_W{1'b0}};
          beat_s  = {BEAT_W{1'b0}};
          state_s = ST_SEND;
        end else begin
          fcnt_s  = fcnt_r + FCNT_W'(1);
        end
      end
      ST_SEND: begin
        if (i_rvalid && i_rready) begin
          beat_s = beat_r + BEAT_W'(1);
          if (is_last_beat(beat_r)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          beat_s = beat_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      fcnt_r  <= {FCNT_W{1'b0}};
      beat_r  <= {BEAT_W{1'b0}};
      line_r  <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_s;
      fcnt_r  <= fcnt_s;
      beat_r  <= beat_s;
      line_r  <= line_s;
    end
  end

  // Line buffer capture; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_r[buf_idx_s] <= ram_rdata_s;
    end
  end

  assign i_arready = !rst && (state_r == ST_IDLE);
  assign i_rvalid  = !rst && (state_r == ST_SEND);
  assign i_rdata   = i_rvalid ? buf_r[beat_r] : {DATA_W{1'b0}};
  assign i_rlast   = i_rvalid && is_last_beat(beat_r);

endmodule

// File: doc/icache_axi_responder.md
ICACHE_AXI_RESPONDER -- requirements
Module: icache_axi_responder

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter RAM_AW, default 12: word-address width of the backing RAM (4096 x 32-bit words).
REQ-003 Port clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port i_arvalid  input  1  read-address request from the instruction cache.
REQ-006 Port i_araddr  input  32  byte address of the requested line; bits [3:0] are ignored.
REQ-007 Port i_arready  output  1  address accepted when high together with i_arvalid.
REQ-008 Port i_rvalid  output  1  read beat valid.
REQ-009 Port i_rready  input  1  cache accepts the current beat.
REQ-010 Port i_rdata  output  32  read beat data.
REQ-011 Port i_rlast  output  1  marks the 4th (final) beat of the line.
REQ-012 Port ld_we, ld_addr[RAM_AW-1:0], ld_wdata[31:0]  input  bench/boot preload write port: one word per cycle.

Function
REQ-013 The FSM SHALL have three states: IDLE, FETCH and SEND.
REQ-014 IDLE: i_arready=1, i_rvalid=0, i_rlast=0; on i_arvalid&&i_arready, latch line index i_araddr[RAM_AW+1:4] and go to FETCH with fetch counter 0.
REQ-015 FETCH lasts exactly 5 cycles (counter 0..4): when counter<4, issue a RAM read of word {line,counter[1:0]}; when counter>=1, write returned RAM data into line buffer entry counter-1; at counter 4, go to SEND with beat counter 0.
REQ-016 SEND: i_rvalid=1, i_rdata=buffer[beat], i_rlast=(beat==3); on i_rvalid&&i_rready, increment beat; on the handshake with beat==3, go to IDLE.
REQ-017 i_rdata and i_rlast SHALL remain stable while i_rvalid=1 and i_rready=0.
REQ-018 i_arready SHALL be 0 in FETCH and SEND; only one outstanding line is supported.
REQ-019 Latency: AR handshake in cycle T gives first i_rvalid in T+6; with i_rready held 1, i_rlast is in T+9 and i_arready is 1 again in T+10.
REQ-020 Beats SHALL be returned in ascending word order 0,1,2,3 (no critical-word-first or wrap burst).
REQ-021 Address bits above RAM_AW+1 SHALL be ignored, so out-of-range addresses alias modulo RAM size.
REQ-022 ld_we SHALL be honoured in every state; a same-cycle read and write to the same word returns the old data (read-first).
REQ-023 Preload writes landing after a word has been captured into the line buffer SHALL NOT change that in-flight line.
REQ-024 i_arvalid in the same cycle as the final i_rlast handshake SHALL NOT be accepted; it is accepted in the following IDLE cycle.

Reset
REQ-025 While rst=1: state<=IDLE, counters<=0, i_arready=0, i_rvalid=0, i_rlast=0, i_rdata=0.
REQ-026 rst asserted mid-FETCH or mid-SEND SHALL abort the burst, with i_rvalid low from the next cycle; no further beats of that line are sent.
REQ-027 RAM contents SHALL NOT be cleared by reset; line-buffer contents are don't-care after reset.

Structure
REQ-028 A shared package SHALL hold the state encoding, BEATS=4, LINE_OFFSET_W=4 and the 32-bit data/address width constants.
REQ-029 The backing store SHALL be a sub-module inst_ram: single clock, one synchronous read port with 1-cycle latency, one write port, read-first, RAM_AW parameter.
REQ-030 The FSM, counters and 4x32 line buffer SHALL reside in icache_axi_responder; i_arready is decoded combinationally from state and rst.

Verification
REQ-031 Preload words 0x100..0x103 with 0xA0..0xA3; AR 0x0000_0400 at T with i_rready=1 -> beats 0xA0,0xA1,0xA2,0xA3 in T+6..T+9, i_rlast only at T+9, i_arready=1 at T+10.
REQ-032 Same line with i_rready toggling 1,0,0,1,... -> each beat held stable while stalled; 4 beats delivered exactly once in order.
REQ-033 AR 0x0000_040C -> identical response to 0x0000_0400 (offset ignored); AR 0x0000_4400 with RAM_AW=12 -> aliases to the same line.
REQ-034 i_arvalid held high across an entire burst -> second request accepted only in the IDLE cycle after i_rlast, second line correct.
REQ-035 rst pulsed for 1 cycle during beat 2 of SEND -> i_rvalid=0 next cycle, i_arready=1 after rst drops, next request returns correct data.
REQ-036 ld_we to word 0x101 with 0xFF in FETCH counter 3 -> in-flight beat 1 returns 0xA1; a subsequent read of the line returns 0xFF.
